// File: rtl/dmem_resp.sv
// Data-memory responder for the core load/store port: one request at a time,
// LATENCY wait states, RV32I sub-word access and fault flagging.
// Optional build macro DMEM_STATS_EN adds saturating load/store response counters.
module dmem_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_Req,
    input  logic        i_WE,
    input  logic [31:0] i_Addr,
    input  logic [2:0]  i_Size,
    input  logic [31:0] i_WriteData,
    output logic        o_Ready,
    output logic        o_Valid,
    output logic [31:0] o_ReadData,
    output logic        o_Err
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] o_LoadCount,
    output logic [15:0] o_StoreCount
`endif
);

    localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(64'(DEPTH_WORDS) * 64'd4);
    localparam logic [3:0]  LAT_INIT   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Fault rules: alignment by size, illegal encodings, unsigned stores, range.
    function automatic logic req_fault(input logic we, input logic [31:0] addr,
                                       input logic [2:0] size);
        logic f;
        case (size)
            3'b000:  f = 1'b0;
            3'b001:  f = addr[0];
            3'b010:  f = |addr[1:0];
            3'b100:  f = we;
            3'b101:  f = we | addr[0];
            default: f = 1'b1;
        endcase
        f = f | ({1'b0, addr} >= ADDR_LIMIT);
        return f;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0] lane,
                                                input logic [2:0] size);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] lane, input logic [2:0] size);
        logic [3:0] be;
        case (size)
            3'b000:  be = 4'b0001 << lane;
            3'b001:  be = lane[1] ? 4'b1100 : 4'b0011;
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    state_t      state_r, state_nx_s;
    logic [3:0]  cnt_r, cnt_nx_s;
    logic        lat_we_r;
    logic [31:0] lat_addr_r;
    logic [2:0]  lat_size_r;
    logic [31:0] lat_wdata_r;
    logic        ready_r, valid_r, err_r;
    logic [31:0] rdata_r;

    logic        op_we_s;
    logic [31:0] op_addr_s;
    logic [2:0]  op_size_s;
    logic [31:0] op_wdata_s;
    logic        access_s, fault_s, mem_we_s;
    logic [AW-1:0] word_idx_s;
    logic [31:0] rd_word_s, wlanes_s;
    logic [3:0]  be_s;

    logic [31:0] mem_r [DEPTH_WORDS];

    // Next-state and wait counter.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (i_Req) begin
                    if (LATENCY == 0) begin
                        state_nx_s = RESP;
                    end else begin
                        state_nx_s = WAIT;
                        cnt_nx_s   = LAT_INIT;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nx_s = RESP;
                end else begin
                    cnt_nx_s = cnt_r - 4'd1;
                end
            end
            RESP:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // With zero latency the access happens on the accepting edge, so use live inputs.
    always_comb begin
        if (state_r == IDLE) begin
            op_we_s    = i_WE;
            op_addr_s  = i_Addr;
            op_size_s  = i_Size;
            op_wdata_s = i_WriteData;
        end else begin
            op_we_s    = lat_we_r;
            op_addr_s  = lat_addr_r;
            op_size_s  = lat_size_r;
            op_wdata_s = lat_wdata_r;
        end
    end

    // Access decode for the edge entering RESP.
    always_comb begin
        access_s   = (state_nx_s == RESP);
        fault_s    = req_fault(op_we_s, op_addr_s, op_size_s);
        mem_we_s   = access_s & op_we_s & ~fault_s;
        word_idx_s = op_addr_s[AW+1:2];
        rd_word_s  = mem_r[word_idx_s];
        be_s       = byte_enables(op_addr_s[1:0], op_size_s);
        case (op_size_s)
            3'b000:  wlanes_s = {4{op_wdata_s[7:0]}};
            3'b001:  wlanes_s = {2{op_wdata_s[15:0]}};
            default: wlanes_s = op_wdata_s;
        endcase
    end

    // FSM state, counter and handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            ready_r <= (state_nx_s == IDLE);
            valid_r <= (state_nx_s == RESP);
        end
    end

    // Request capture on acceptance and registered response data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_we_r    <= 1'b0;
            lat_addr_r  <= 32'd0;
            lat_size_r  <= 3'd0;
            lat_wdata_r <= 32'd0;
            rdata_r     <= 32'd0;
            err_r       <= 1'b0;
        end else begin
            if ((state_r == IDLE) && i_Req) begin
                lat_we_r    <= i_WE;
                lat_addr_r  <= i_Addr;
                lat_size_r  <= i_Size;
                lat_wdata_r <= i_WriteData;
            end
            if (access_s) begin
                err_r   <= fault_s;
                rdata_r <= (fault_s || op_we_s) ? 32'd0
                         : load_extend(rd_word_s, op_addr_s[1:0], op_size_s);
            end
        end
    end

    // Storage array: per-byte writes, contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[word_idx_s][8*i +: 8] <= wlanes_s[8*i +: 8];
                end
            end
        end
    end

    assign o_Ready    = ready_r;
    assign o_Valid    = valid_r;
    assign o_ReadData = rdata_r;
    assign o_Err      = err_r;

`ifdef DMEM_STATS_EN
    logic [15:0] load_cnt_r, store_cnt_r;

    // Saturating counts of error-free responses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_cnt_r  <= 16'd0;
            store_cnt_r <= 16'd0;
        end else if (access_s && !fault_s) begin
            if (op_we_s) begin
                if (store_cnt_r != 16'hFFFF) store_cnt_r <= store_cnt_r + 16'd1;
            end else begin
                if (load_cnt_r != 16'hFFFF) load_cnt_r <= load_cnt_r + 16'd1;
            end
        end
    end

    assign o_LoadCount  = load_cnt_r;
    assign o_StoreCount = store_cnt_r;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: directed checks on a LATENCY=2 instance and a randomized
// run against a byte-array reference model on a small LATENCY=0 instance.
module tb_dmem_resp;

    localparam int LAT0 = 2;
    localparam int LAT1 = 0;
    localparam int DEPTH1 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        req [2];
    logic        we [2];
    logic [31:0] addr [2];
    logic [2:0]  size [2];
    logic [31:0] wd [2];
    logic        ready [2];
    logic        valid [2];
    logic [31:0] rdata [2];
    logic        err [2];
`ifdef DMEM_STATS_EN
    logic [15:0] ldc [2];
    logic [15:0] stc [2];
`endif

    dmem_resp #(.DEPTH_WORDS(1024), .LATENCY(LAT0)) dut0 (
        .clk(clk), .reset_n(reset_n), .i_Req(req[0]), .i_WE(we[0]), .i_Addr(addr[0]),
        .i_Size(size[0]), .i_WriteData(wd[0]), .o_Ready(ready[0]), .o_Valid(valid[0]),
        .o_ReadData(rdata[0]), .o_Err(err[0])
`ifdef DMEM_STATS_EN
        , .o_LoadCount(ldc[0]), .o_StoreCount(stc[0])
`endif
    );

    dmem_resp #(.DEPTH_WORDS(DEPTH1), .LATENCY(LAT1)) dut1 (
        .clk(clk), .reset_n(reset_n), .i_Req(req[1]), .i_WE(we[1]), .i_Addr(addr[1]),
        .i_Size(size[1]), .i_WriteData(wd[1]), .o_Ready(ready[1]), .o_Valid(valid[1]),
        .o_ReadData(rdata[1]), .o_Err(err[1])
`ifdef DMEM_STATS_EN
        , .o_LoadCount(ldc[1]), .o_StoreCount(stc[1])
`endif
    );

    int total = 0;
    int bad = 0;
    logic [7:0] mdl [4*DEPTH1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed memory, access width from funct3, arithmetic extension.
    function automatic void model(input logic w, input logic [31:0] a, input logic [2:0] sz,
                                  input logic [31:0] d, output logic [31:0] rd, output logic er);
        int n;
        longint v;
        n = (sz == 3'd0 || sz == 3'd4) ? 1 : (sz == 3'd1 || sz == 3'd5) ? 2 : (sz == 3'd2) ? 4 : 0;
        er = (n == 0) || (w && sz >= 3'd4) || (a >= 32'(4*DEPTH1)) || (n != 0 && (a % n) != 0);
        rd = 32'd0;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < n; i++) mdl[int'(a) + i] = 8'(d >> (8*i));
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v += longint'(mdl[int'(a) + i]) << (8*i);
                if (sz < 3'd4 && v >= (longint'(1) << (8*n - 1))) v -= longint'(1) << (8*n);
                rd = 32'(v);
            end
        end
    endfunction

    task automatic xact(input int s, input logic w, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] d, output logic [31:0] rd, output logic er);
        int lat;
        bit seen;
        @(negedge clk);
        chk("ready_idle", 32'(ready[s]), 32'd1);
        req[s] = 1'b1; we[s] = w; addr[s] = a; size[s] = sz; wd[s] = d;
        @(posedge clk);
        #1 req[s] = 1'b0;
        seen = 1'b0;
        lat = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (valid[s] === 1'b1) seen = 1'b1;
        end
        chk("valid_seen", 32'(seen), 32'd1);
        chk("latency", 32'(lat), 32'((s == 0 ? LAT0 : LAT1) + 1));
        rd = rdata[s];
        er = err[s];
    endtask

    task automatic op(input int s, input logic w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_er,
                      input string tag);
        logic [31:0] rd;
        logic er;
        xact(s, w, a, sz, d, rd, er);
        chk({tag, "_data"}, rd, exp_rd);
        chk({tag, "_err"}, 32'(er), 32'(exp_er));
    endtask

    task automatic mop(input logic w, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] d, input string tag);
        logic [31:0] erd;
        logic eer;
        model(w, a, sz, d, erd, eer);
        op(1, w, a, sz, d, erd, eer, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tw [4];
        logic [2:0]  tsz [4];
        logic        twe [4];
        logic [31:0] td [4];
        logic [31:0] erd [4];
        logic        eer [4];
        int k;
        bit seen;
        logic [31:0] a;

        reset_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0; we[s] = 1'b0; addr[s] = 32'd0; size[s] = 3'd0; wd[s] = 32'd0;
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(ready[0]), 32'd1);
        chk("rst_valid", 32'(valid[0]), 32'd0);
        chk("rst_rdata", rdata[0], 32'd0);
        chk("rst_err", 32'(err[0]), 32'd0);

        op(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 32'd0, 1'b0, "sw_beef");
        op(0, 1'b0, 32'h10, 3'd2, 32'd0, 32'hDEADBEEF, 1'b0, "lw_beef");

        op(0, 1'b1, 32'h10, 3'd2, 32'h11223344, 32'd0, 1'b0, "sw_1122");
        op(0, 1'b1, 32'h13, 3'd0, 32'hABCDEF80, 32'd0, 1'b0, "sb_80");
        op(0, 1'b0, 32'h10, 3'd2, 32'd0, 32'h80223344, 1'b0, "lw_merge");
        op(0, 1'b0, 32'h13, 3'd0, 32'd0, 32'hFFFFFF80, 1'b0, "lb_13");
        op(0, 1'b0, 32'h13, 3'd4, 32'd0, 32'h00000080, 1'b0, "lbu_13");
        op(0, 1'b0, 32'h12, 3'd1, 32'd0, 32'hFFFF8022, 1'b0, "lh_12");
        @(negedge clk);
        chk("hold_valid", 32'(valid[0]), 32'd0);
        chk("hold_rdata", rdata[0], 32'hFFFF8022);

        op(0, 1'b1, 32'h0, 3'd2, 32'h0BADF00D, 32'd0, 1'b0, "sw_0");
        op(0, 1'b0, 32'h2, 3'd2, 32'd0, 32'd0, 1'b1, "lw_mis");
        op(0, 1'b0, 32'h1, 3'd1, 32'd0, 32'd0, 1'b1, "lh_mis");
        op(0, 1'b1, 32'd4096, 3'd2, 32'h12345678, 32'd0, 1'b1, "sw_oob");
        op(0, 1'b0, 32'h0, 3'd3, 32'd0, 32'd0, 1'b1, "size_011");
        op(0, 1'b1, 32'h0, 3'd4, 32'hFFFFFFFF, 32'd0, 1'b1, "sbu_store");
        op(0, 1'b0, 32'h0, 3'd2, 32'd0, 32'h0BADF00D, 1'b0, "lw_unchanged");
        op(0, 1'b1, 32'd4092, 3'd2, 32'hCAFEF00D, 32'd0, 1'b0, "sw_last");
        op(0, 1'b0, 32'd4092, 3'd2, 32'd0, 32'hCAFEF00D, 1'b0, "lw_last");

        // Reset pulse while a store waits: it must never respond nor write.
        op(0, 1'b1, 32'h20, 3'd2, 32'h12345678, 32'd0, 1'b0, "sw_20");
        op(0, 1'b0, 32'h20, 3'd2, 32'd0, 32'h12345678, 1'b0, "lw_20");
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; size[0] = 3'd2; wd[0] = 32'h55;
        @(posedge clk);
        #1 req[0] = 1'b0;
        @(negedge clk);
        chk("wait_ready", 32'(ready[0]), 32'd0);
        chk("wait_hold", rdata[0], 32'h12345678);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(ready[0]), 32'd1);
        chk("mid_rst_valid", 32'(valid[0]), 32'd0);
        chk("mid_rst_rdata", rdata[0], 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (valid[0] === 1'b1) seen = 1'b1;
        end
        chk("aborted_no_valid", 32'(seen), 32'd0);
        op(0, 1'b0, 32'h20, 3'd2, 32'd0, 32'h12345678, 1'b0, "lw_20_kept");

        // Fill the small instance so every model byte is defined.
        for (int i = 0; i < DEPTH1; i++) mop(1'b1, 32'(4*i), 3'd2, $urandom, "init");

        // Back-to-back requests with i_Req held high on the zero-latency instance.
        twe[0] = 1'b1; tw[0] = 32'h8; tsz[0] = 3'd2; td[0] = $urandom;
        twe[1] = 1'b0; tw[1] = 32'h8; tsz[1] = 3'd2; td[1] = 32'd0;
        twe[2] = 1'b1; tw[2] = 32'h9; tsz[2] = 3'd0; td[2] = $urandom;
        twe[3] = 1'b0; tw[3] = 32'h8; tsz[3] = 3'd1; td[3] = 32'd0;
        for (int i = 0; i < 4; i++) model(twe[i], tw[i], tsz[i], td[i], erd[i], eer[i]);
        @(negedge clk);
        req[1] = 1'b1; we[1] = twe[0]; addr[1] = tw[0]; size[1] = tsz[0]; wd[1] = td[0];
        k = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("tp_valid", 32'(valid[1]), 32'(c % 2));
            chk("tp_ready", 32'(ready[1]), 32'(1 - c % 2));
            if (valid[1] === 1'b1 && k < 4) begin
                chk("tp_data", rdata[1], erd[k]);
                chk("tp_err", 32'(err[1]), 32'(eer[k]));
                k++;
                if (k < 4) begin
                    we[1] = twe[k]; addr[1] = tw[k]; size[1] = tsz[k]; wd[1] = td[k];
                end else begin
                    req[1] = 1'b0;
                end
            end
        end
        req[1] = 1'b0;
        chk("tp_count", 32'(k), 32'd4);

        // Random mix including illegal sizes, misalignment and out-of-range addresses.
        for (int i = 0; i < 200; i++) begin
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH1 + 7));
            mop(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom, "rand");
        end

`ifdef DMEM_STATS_EN
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("stats_rst_ld", 32'(ldc[0]), 32'd0);
        op(0, 1'b1, 32'h40, 3'd2, 32'h01020304, 32'd0, 1'b0, "st_sw");
        op(0, 1'b1, 32'h41, 3'd0, 32'h000000AA, 32'd0, 1'b0, "st_sb");
        op(0, 1'b0, 32'h40, 3'd2, 32'd0, 32'h0102AA04, 1'b0, "st_lw");
        op(0, 1'b0, 32'h41, 3'd4, 32'd0, 32'h000000AA, 1'b0, "st_lbu");
        op(0, 1'b0, 32'h42, 3'd5, 32'd0, 32'h00000102, 1'b0, "st_lhu");
        op(0, 1'b0, 32'h42, 3'd2, 32'd0, 32'd0, 1'b1, "st_bad");
        chk("stats_loads", 32'(ldc[0]), 32'd3);
        chk("stats_stores", 32'(stc[0]), 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
